fetch_stage: RTL and testbench

- Instruction fetch unit plus IF/ID pipeline register, directly upstream of the main decoder.
- Holds the PC and issues word fetches to instruction memory over a req/ack handshake.
- Presents the fetched instruction, PC+4 and the opcode field (instr[31:26]) to the decode stage.
- Honours decode stalls and branch/jump redirects from the later stages.

---
 rtl/fetch_stage_pkg.sv | 24 ++
 rtl/fetch_stage_if.sv | 14 +
 rtl/fetch_stage_if_id_reg.sv | 62 ++++++
 rtl/fetch_stage.sv | 160 ++++++++++++++++
 tb/tb_fetch_stage.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// default reset PC / NOP word and instruction field positions.
package fetch_stage_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;

  localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FETCH     = 2'd1,
    ST_WAIT_SLOT = 2'd2,
    ST_KILL      = 2'd3
  } fetch_state_e;

  // Instructions are word aligned; the two low address bits carry no meaning.
  function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bundle between fetch (master)
// and the instruction memory (slave).
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic               imem_req;
  logic [INSTR_W-1:0] imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold, and an idle
// unstalled cycle empties the slot to the NOP word.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               hold_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [INSTR_W-1:0] pc4_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [INSTR_W-1:0] pc4_o
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] pc4_q, pc4_d;

  // Next-state selection for the slot.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (flush_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc4_d   = pc4_i;
    end else if (hold_i) begin
      valid_d = valid_q;
      instr_d = instr_q;
    end else begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

  // Slot registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0000_0000;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, request FSM with a one-entry skid buffer and
// wrong-path kill, feeding the IF/ID register toward decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_id,
  input  logic               redirect,
  input  logic [INSTR_W-1:0] redirect_pc,
  fetch_stage_if.master      imem,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [INSTR_W-1:0] if_id_pc4,
  output logic [5:0]         if_id_opcode
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] pending_pc_q, pending_pc_d;
  logic               skid_valid_q, skid_valid_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [INSTR_W-1:0] skid_pc4_q, skid_pc4_d;

  logic               slot_free;
  logic [INSTR_W-1:0] pc_plus4;
  logic [INSTR_W-1:0] redirect_tgt;
  logic               load;
  logic [INSTR_W-1:0] load_instr;
  logic [INSTR_W-1:0] load_pc4;

  assign slot_free    = !if_id_valid || !stall_id;
  assign pc_plus4     = pc_q + 32'd4;
  assign redirect_tgt = word_align(redirect_pc);

  // Fetch FSM next state, PC and skid buffer control.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_pc_d = pending_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    load         = 1'b0;
    load_instr   = imem.imem_rdata;
    load_pc4     = pc_plus4;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        if (redirect) begin
          pc_d = redirect_tgt;
        end else begin
          pc_d = pc_q;
        end
      end
      ST_FETCH: begin
        if (imem.imem_ack) begin
          if (redirect) begin
            pc_d = redirect_tgt;
          end else if (slot_free) begin
            load = 1'b1;
            pc_d = pc_plus4;
          end else begin
            skid_valid_d = 1'b1;
            skid_instr_d = imem.imem_rdata;
            skid_pc4_d   = pc_plus4;
            pc_d         = pc_plus4;
            state_d      = ST_WAIT_SLOT;
          end
        end else if (redirect) begin
          // The in-flight request is wrong-path; let it drain in KILL.
          pending_pc_d = redirect_tgt;
          state_d      = ST_KILL;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WAIT_SLOT: begin
        if (redirect) begin
          pc_d    = redirect_tgt;
          state_d = ST_FETCH;
        end else if (slot_free && skid_valid_q) begin
          load         = 1'b1;
          load_instr   = skid_instr_q;
          load_pc4     = skid_pc4_q;
          skid_valid_d = 1'b0;
          state_d      = ST_FETCH;
        end else begin
          state_d = ST_WAIT_SLOT;
        end
      end
      ST_KILL: begin
        if (redirect) begin
          pending_pc_d = redirect_tgt;
        end else begin
          pending_pc_d = pending_pc_q;
        end
        if (imem.imem_ack) begin
          pc_d    = redirect ? redirect_tgt : pending_pc_q;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_KILL;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (redirect) begin
      skid_valid_d = 1'b0;
    end else begin
      skid_valid_d = skid_valid_d;
    end
  end

  // FSM, PC and skid registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      pending_pc_q <= RESET_PC;
      skid_valid_q <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc4_q   <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  assign imem.imem_req  = (state_q == ST_FETCH) || (state_q == ST_KILL);
  assign imem.imem_addr = pc_q;

  fetch_stage_if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk    (clk),
    .reset  (reset),
    .load_i (load),
    .hold_i (stall_id),
    .flush_i(redirect),
    .instr_i(load_instr),
    .pc4_i  (load_pc4),
    .valid_o(if_id_valid),
    .instr_o(if_id_instr),
    .pc4_o  (if_id_pc4)
  );

  assign if_id_opcode = if_id_instr[OPC_MSB:OPC_LSB];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run scored
// against an in-order instruction-stream model with a synthetic memory.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall_id;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic [5:0]  if_id_opcode;

  logic        reset2;
  logic        valid2;
  logic [31:0] instr2;
  logic [31:0] pc4_2;
  logic [5:0]  opcode2;

  int tests_run;
  int tests_failed;

  fetch_stage_if imem_if ();
  fetch_stage_if imem_if2 ();

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall_id    (stall_id),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem_if.master),
    .if_id_valid (if_id_valid),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_opcode(if_id_opcode)
  );

  fetch_stage #(
    .RESET_PC(32'hFFFF_FFFC)
  ) dut_wrap (
    .clk         (clk),
    .reset       (reset2),
    .stall_id    (1'b0),
    .redirect    (1'b0),
    .redirect_pc (32'h0000_0000),
    .imem        (imem_if2.master),
    .if_id_valid (valid2),
    .if_id_instr (instr2),
    .if_id_pc4   (pc4_2),
    .if_id_opcode(opcode2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synthetic instruction memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Random-phase model state
  logic [31:0] exp_pc;
  int          accepted;
  logic        prev_reset, prev_redirect, prev_req, prev_ack;
  logic [31:0] prev_addr;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    reset2       = 1'b1;
    stall_id     = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = 32'h0000_0000;
    imem_if.imem_ack    = 1'b0;
    imem_if.imem_rdata  = 32'h0000_0000;
    imem_if2.imem_ack   = 1'b0;
    imem_if2.imem_rdata = 32'h0000_0000;

    // 1: reset state, first fetch with ack one cycle after req
    tick(); tick();
    chk("rst_req",   32'(imem_if.imem_req), 32'h0);
    chk("rst_addr",  imem_if.imem_addr, 32'h0);
    chk("rst_valid", 32'(if_id_valid), 32'h0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_pc4",   if_id_pc4, 32'h0);
    reset = 1'b0;
    tick();
    chk("t1_req",  32'(imem_if.imem_req), 32'h1);
    chk("t1_addr", imem_if.imem_addr, 32'h0);
    tick();
    chk("t1_req_hold",  32'(imem_if.imem_req), 32'h1);
    chk("t1_addr_hold", imem_if.imem_addr, 32'h0);
    imem_if.imem_ack   = 1'b1;
    imem_if.imem_rdata = 32'h8C22_0004;
    tick();
    imem_if.imem_ack = 1'b0;
    chk("t1_valid",  32'(if_id_valid), 32'h1);
    chk("t1_instr",  if_id_instr, 32'h8C22_0004);
    chk("t1_pc4",    if_id_pc4, 32'h4);
    chk("t1_opcode", 32'(if_id_opcode), 32'h23);

    // 2: same-cycle acks, one instruction per cycle
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        chk("t2_valid", 32'(if_id_valid), 32'h1);
        chk("t2_pc4",   if_id_pc4, 32'(4 * k));
        chk("t2_instr", if_id_instr, mem_word(32'(4 * (k - 1))));
      end
      chk("t2_addr", imem_if.imem_addr, 32'(4 * k));
      imem_if.imem_ack   = 1'b1;
      imem_if.imem_rdata = mem_word(imem_if.imem_addr);
      tick();
    end
    chk("t2_valid4", 32'(if_id_valid), 32'h1);
    chk("t2_pc4_4",  if_id_pc4, 32'h10);
    chk("t2_addr4",  imem_if.imem_addr, 32'h10);

    // 3: stall while a fetch acks -> skid, then drain
    stall_id           = 1'b1;
    imem_if.imem_ack   = 1'b1;
    imem_if.imem_rdata = mem_word(32'h10);
    tick();
    imem_if.imem_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("t3_req_wait", 32'(imem_if.imem_req), 32'h0);
      chk("t3_hold_pc4", if_id_pc4, 32'h10);
      chk("t3_hold_ins", if_id_instr, mem_word(32'hC));
      tick();
    end
    chk("t3_req_wait3", 32'(imem_if.imem_req), 32'h0);
    stall_id = 1'b0;
    tick();
    chk("t3_skid_valid", 32'(if_id_valid), 32'h1);
    chk("t3_skid_instr", if_id_instr, mem_word(32'h10));
    chk("t3_skid_pc4",   if_id_pc4, 32'h14);
    chk("t3_req_resume", 32'(imem_if.imem_req), 32'h1);
    chk("t3_addr_next",  imem_if.imem_addr, 32'h14);

    // 4: redirect with a request outstanding, ack three cycles later
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t4_valid", 32'(if_id_valid), 32'h0);
      chk("t4_req",   32'(imem_if.imem_req), 32'h1);
      chk("t4_addr",  imem_if.imem_addr, 32'h14);
      if (k == 2) begin
        imem_if.imem_ack   = 1'b1;
        imem_if.imem_rdata = mem_word(32'h14);
      end
      tick();
    end
    chk("t4_stale_valid", 32'(if_id_valid), 32'h0);
    chk("t4_new_addr",    imem_if.imem_addr, 32'h40);

    // 5: redirect, stall and ack together
    imem_if.imem_rdata = mem_word(32'h40);
    tick();
    chk("t5_pre_valid", 32'(if_id_valid), 32'h1);
    chk("t5_pre_pc4",   if_id_pc4, 32'h44);
    redirect           = 1'b1;
    redirect_pc        = 32'h80;
    stall_id           = 1'b1;
    imem_if.imem_ack   = 1'b1;
    imem_if.imem_rdata = mem_word(32'h44);
    tick();
    redirect         = 1'b0;
    stall_id         = 1'b0;
    imem_if.imem_ack = 1'b0;
    chk("t5_valid", 32'(if_id_valid), 32'h0);
    chk("t5_instr", if_id_instr, 32'h0);
    chk("t5_addr",  imem_if.imem_addr, 32'h80);

    // Randomized run against the in-order stream model
    reset         = 1'b1;
    exp_pc        = 32'h0;
    accepted      = 0;
    prev_reset    = 1'b1;
    prev_redirect = 1'b0;
    prev_req      = 1'b0;
    prev_ack      = 1'b0;
    prev_addr     = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (prev_reset) begin
        chk("rnd_rst_req",   32'(imem_if.imem_req), 32'h0);
        chk("rnd_rst_valid", 32'(if_id_valid), 32'h0);
        chk("rnd_rst_addr",  imem_if.imem_addr, 32'h0);
      end else begin
        if (prev_redirect) chk("rnd_flush", 32'(if_id_valid), 32'h0);
        if (prev_req && !prev_ack) begin
          chk("rnd_req_held",  32'(imem_if.imem_req), 32'h1);
          chk("rnd_addr_held", imem_if.imem_addr, prev_addr);
        end
      end
      if (if_id_valid) chk("rnd_opcode", 32'(if_id_opcode), 32'(if_id_instr[31:26]));

      reset       = ($urandom_range(0, 199) == 0);
      stall_id    = ($urandom_range(0, 2) == 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom_range(0, 1023);
      imem_if.imem_ack   = imem_if.imem_req && ($urandom_range(0, 1) == 1);
      imem_if.imem_rdata = imem_if.imem_ack ? mem_word(imem_if.imem_addr) : $urandom();

      if (reset) begin
        exp_pc = 32'h0;
      end else if (redirect) begin
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (if_id_valid && !stall_id) begin
        chk("rnd_instr", if_id_instr, mem_word(exp_pc));
        chk("rnd_pc4",   if_id_pc4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        accepted++;
      end

      prev_reset    = reset;
      prev_redirect = redirect;
      prev_req      = imem_if.imem_req;
      prev_ack      = imem_if.imem_ack;
      prev_addr     = imem_if.imem_addr;
    end
    reset            = 1'b0;
    stall_id         = 1'b0;
    redirect         = 1'b0;
    imem_if.imem_ack = 1'b0;
    chk("rnd_progress", 32'(accepted > 100), 32'h1);

    // 6: PC wrap from 0xFFFF_FFFC
    tick();
    chk("t6_rst_req",  32'(imem_if2.imem_req), 32'h0);
    chk("t6_rst_addr", imem_if2.imem_addr, 32'hFFFF_FFFC);
    reset2 = 1'b0;
    tick();
    chk("t6_req",  32'(imem_if2.imem_req), 32'h1);
    chk("t6_addr", imem_if2.imem_addr, 32'hFFFF_FFFC);
    imem_if2.imem_ack   = 1'b1;
    imem_if2.imem_rdata = mem_word(32'hFFFF_FFFC);
    tick();
    imem_if2.imem_ack = 1'b0;
    chk("t6_valid",  32'(valid2), 32'h1);
    chk("t6_instr",  instr2, mem_word(32'hFFFF_FFFC));
    chk("t6_pc4",    pc4_2, 32'h0);
    chk("t6_addr2",  imem_if2.imem_addr, 32'h0);
    chk("t6_opcode", 32'(opcode2), 32'(mem_word(32'hFFFF_FFFC) >> 26));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
